// File: rtl/ni_flit_injector_if.sv
// Endpoint-to-router injection bundle: packet descriptor, body words, flit output,
// per-VC credit return and status.
interface ni_flit_injector_if #(
  parameter int V    = 4,
  parameter int Fpay = 32,
  parameter int Lw   = 5
);
  localparam int Fw = 2 + V + Fpay;

  logic            pck_valid;
  logic            pck_ready;
  logic [V-1:0]    pck_vc;
  logic [Lw-1:0]   pck_len;
  logic [Fpay-1:0] pck_hdr;
  logic [Fpay-1:0] data_in;
  logic            data_valid;
  logic            data_ready;
  logic [Fw-1:0]   flit_out;
  logic            flit_out_we;
  logic [V-1:0]    credit_in;
  logic [V-1:0]    vc_full;
  logic            busy;
  logic            err;

  // The endpoint/router side drives descriptors, data and credits.
  modport master (
    output pck_valid, pck_vc, pck_len, pck_hdr, data_in, data_valid, credit_in,
    input  pck_ready, data_ready, flit_out, flit_out_we, vc_full, busy, err
  );

  // The injector consumes them and produces flits and status.
  modport slave (
    input  pck_valid, pck_vc, pck_len, pck_hdr, data_in, data_valid, credit_in,
    output pck_ready, data_ready, flit_out, flit_out_we, vc_full, busy, err
  );
endinterface

// File: rtl/ni_flit_injector.sv
// Segments local packets into header/body/tail flits and issues them under per-VC credit control.
// state | meaning
// IDLE  | waiting for a descriptor; pck_ready high
// HEAD  | descriptor latched; header flit issues when the VC has a credit
// BODY  | body/tail words forwarded one per transfer until remaining hits zero
module ni_flit_injector #(
  parameter int V    = 4,
  parameter int B    = 4,
  parameter int Fpay = 32,
  parameter int Lw   = 5
) (
  input  logic               clk,
  input  logic               reset,
  ni_flit_injector_if.slave  bus
);
  localparam int CW = $clog2(B + 1);
  localparam int FW = 2 + V + Fpay;
  localparam logic [CW-1:0] CRED_MAX = CW'(B);

  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

  state_t                r_state;
  logic [V-1:0]          r_vc;
  logic [Lw-1:0]         r_len;
  logic [Lw-1:0]         r_rem;
  logic [Fpay-1:0]       r_hdr;
  logic [V-1:0][CW-1:0]  r_credit;
  logic [V-1:0]          r_vc_full;
  logic [FW-1:0]         r_flit;
  logic                  r_we;
  logic                  r_err;

  logic                  w_req_ok;
  logic                  w_cred_ok;
  logic                  w_data_xfer;
  logic                  w_issue;
  logic [V-1:0]          w_dec;
  logic [V-1:0]          w_at_max;
  logic                  w_ovf;

  assign w_req_ok    = (bus.pck_vc != '0) &&
                       ((bus.pck_vc & (bus.pck_vc - V'(1))) == '0) &&
                       (bus.pck_len != '0);
  assign w_cred_ok   = |(r_vc & ~r_vc_full);
  assign w_data_xfer = (r_state == BODY) && w_cred_ok && bus.data_valid;
  assign w_issue     = ((r_state == HEAD) && w_cred_ok) || w_data_xfer;
  assign w_dec       = {V{w_issue}} & r_vc;

  genvar gv;
  generate
    for (gv = 0; gv < V; gv++) begin : g_max
      assign w_at_max[gv] = (r_credit[gv] == CRED_MAX);
    end
  endgenerate

  // A credit arriving on a full counter is only an overflow if no flit frees a slot that same edge.
  assign w_ovf = |(bus.credit_in & ~w_dec & w_at_max);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < V; v++) r_credit[v] <= CRED_MAX;
      r_vc_full <= '0;
    end else begin
      for (int v = 0; v < V; v++) begin
        if (bus.credit_in[v] && !w_dec[v]) begin
          if (!w_at_max[v]) begin
            r_credit[v]  <= r_credit[v] + CW'(1);
            r_vc_full[v] <= 1'b0;
          end
        end else if (w_dec[v] && !bus.credit_in[v]) begin
          r_credit[v]  <= r_credit[v] - CW'(1);
          r_vc_full[v] <= (r_credit[v] == CW'(1));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_vc    <= '0;
      r_len   <= '0;
      r_rem   <= '0;
      r_hdr   <= '0;
      r_flit  <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_we  <= 1'b0;
      r_err <= w_ovf;
      case (r_state)
        IDLE: begin
          if (bus.pck_valid) begin
            if (w_req_ok) begin
              r_vc    <= bus.pck_vc;
              r_len   <= bus.pck_len;
              r_rem   <= bus.pck_len;
              r_hdr   <= bus.pck_hdr;
              r_state <= HEAD;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        HEAD: begin
          if (w_cred_ok) begin
            r_flit  <= {1'b1, (r_len == Lw'(1)), r_vc, r_hdr};
            r_we    <= 1'b1;
            r_rem   <= r_rem - Lw'(1);
            r_state <= (r_len == Lw'(1)) ? IDLE : BODY;
          end
        end
        BODY: begin
          if (w_data_xfer) begin
            r_flit <= {1'b0, (r_rem == Lw'(1)), r_vc, bus.data_in};
            r_we   <= 1'b1;
            r_rem  <= r_rem - Lw'(1);
            if (r_rem == Lw'(1)) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.pck_ready   = (r_state == IDLE);
  assign bus.busy        = (r_state != IDLE);
  assign bus.data_ready  = (r_state == BODY) && w_cred_ok;
  assign bus.flit_out    = r_flit;
  assign bus.flit_out_we = r_we;
  assign bus.vc_full     = r_vc_full;
  assign bus.err         = r_err;
endmodule

// File: tb/tb_ni_flit_injector.sv
// Directed bench for ni_flit_injector: one task per scenario with inline expected values.
module tb_ni_flit_injector;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  ni_flit_injector_if #(.V(4), .Fpay(32), .Lw(5)) bus ();

  ni_flit_injector #(.V(4), .B(4), .Fpay(32), .Lw(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] mkf(input logic h, input logic t, input logic [3:0] vc, input logic [31:0] p);
    return {h, t, vc, p};
  endfunction

  task automatic test_reset;
    bus.pck_valid = 0; bus.pck_vc = 0; bus.pck_len = 0; bus.pck_hdr = 0;
    bus.data_in = 0; bus.data_valid = 0; bus.credit_in = 0;
    reset = 1'b0;
    tick; tick;
    n_cmp++; if (bus.flit_out !== 38'd0) begin n_fail++; $display("FAIL rst_flit: got %h want 0", bus.flit_out); end
    n_cmp++; if (bus.flit_out_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b want 0", bus.flit_out_we); end
    n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", bus.err); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.vc_full !== 4'b0000) begin n_fail++; $display("FAIL rst_vc_full: got %b want 0000", bus.vc_full); end
    for (int v = 0; v < 4; v++) begin
      n_cmp++; if (dut.r_credit[v] !== 3'd4) begin n_fail++; $display("FAIL rst_credit%0d: got %0d want 4", v, dut.r_credit[v]); end
    end
    reset = 1'b1;
    tick;
    n_cmp++; if (bus.pck_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", bus.pck_ready); end
  endtask

  task automatic test_single;
    bus.pck_valid = 1; bus.pck_vc = 4'b0010; bus.pck_len = 5'd1; bus.pck_hdr = 32'hA5;
    tick;
    bus.pck_valid = 0;
    n_cmp++; if (bus.flit_out_we !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_n1: got we=%b busy=%b want we=0 busy=1", bus.flit_out_we, bus.busy); end
    tick;
    n_cmp++; if (bus.flit_out_we !== 1'b1) begin n_fail++; $display("FAIL single_we: got %b want 1", bus.flit_out_we); end
    n_cmp++; if (bus.flit_out !== mkf(1, 1, 4'b0010, 32'hA5)) begin n_fail++; $display("FAIL single_flit: got %h want %h", bus.flit_out, mkf(1, 1, 4'b0010, 32'hA5)); end
    n_cmp++; if (dut.r_credit[1] !== 3'd3) begin n_fail++; $display("FAIL single_credit: got %0d want 3", dut.r_credit[1]); end
    n_cmp++; if (bus.pck_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", bus.pck_ready); end
    tick;
    n_cmp++; if (bus.flit_out_we !== 1'b0 || bus.flit_out !== mkf(1, 1, 4'b0010, 32'hA5)) begin n_fail++; $display("FAIL single_hold: got we=%b flit=%h want we=0 flit held", bus.flit_out_we, bus.flit_out); end
    bus.credit_in = 4'b0010;
    tick;
    bus.credit_in = 0;
    n_cmp++; if (dut.r_credit[1] !== 3'd4 || bus.err !== 1'b0) begin n_fail++; $display("FAIL single_return: got credit=%0d err=%b want 4/0", dut.r_credit[1], bus.err); end
  endtask

  task automatic test_four;
    bus.pck_valid = 1; bus.pck_vc = 4'b0001; bus.pck_len = 5'd4; bus.pck_hdr = 32'h12345678;
    bus.data_valid = 1; bus.data_in = 32'd1;
    tick;
    bus.pck_valid = 0;
    tick;
    n_cmp++; if (bus.flit_out_we !== 1'b1 || bus.flit_out !== mkf(1, 0, 4'b0001, 32'h12345678)) begin n_fail++; $display("FAIL four_hdr: got we=%b flit=%h want we=1 flit=%h", bus.flit_out_we, bus.flit_out, mkf(1, 0, 4'b0001, 32'h12345678)); end
    n_cmp++; if (bus.data_ready !== 1'b1) begin n_fail++; $display("FAIL four_ready: got %b want 1", bus.data_ready); end
    for (int k = 1; k <= 3; k++) begin
      bus.data_in = k;
      tick;
      n_cmp++; if (bus.flit_out_we !== 1'b1 || bus.flit_out !== mkf(0, k == 3, 4'b0001, k)) begin n_fail++; $display("FAIL four_body%0d: got we=%b flit=%h want we=1 flit=%h", k, bus.flit_out_we, bus.flit_out, mkf(0, k == 3, 4'b0001, k)); end
    end
    bus.data_valid = 0;
    n_cmp++; if (dut.r_credit[0] !== 3'd0 || bus.vc_full[0] !== 1'b1) begin n_fail++; $display("FAIL four_empty: got credit=%0d full=%b want 0/1", dut.r_credit[0], bus.vc_full[0]); end
    n_cmp++; if (bus.busy !== 1'b0 || bus.data_ready !== 1'b0) begin n_fail++; $display("FAIL four_idle: got busy=%b ready=%b want 0/0", bus.busy, bus.data_ready); end
    tick;
    n_cmp++; if (bus.flit_out_we !== 1'b0) begin n_fail++; $display("FAIL four_we_off: got %b want 0", bus.flit_out_we); end
    bus.credit_in = 4'b0001;
    repeat (4) tick;
    bus.credit_in = 0;
    n_cmp++; if (dut.r_credit[0] !== 3'd4 || bus.vc_full[0] !== 1'b0 || bus.err !== 1'b0) begin n_fail++; $display("FAIL four_restore: got credit=%0d full=%b err=%b want 4/0/0", dut.r_credit[0], bus.vc_full[0], bus.err); end
  endtask

  task automatic test_starve;
    bus.pck_valid = 1; bus.pck_vc = 4'b0100; bus.pck_len = 5'd6; bus.pck_hdr = 32'hCAFE;
    bus.data_valid = 1; bus.data_in = 32'h10;
    tick;
    bus.pck_valid = 0;
    tick;
    n_cmp++; if (bus.flit_out_we !== 1'b1 || bus.flit_out !== mkf(1, 0, 4'b0100, 32'hCAFE)) begin n_fail++; $display("FAIL starve_hdr: got we=%b flit=%h", bus.flit_out_we, bus.flit_out); end
    for (int k = 1; k <= 3; k++) begin
      bus.data_in = 32'h10 + k;
      tick;
      n_cmp++; if (bus.flit_out_we !== 1'b1 || bus.flit_out !== mkf(0, 0, 4'b0100, 32'h10 + k)) begin n_fail++; $display("FAIL starve_body%0d: got we=%b flit=%h want %h", k, bus.flit_out_we, bus.flit_out, mkf(0, 0, 4'b0100, 32'h10 + k)); end
    end
    bus.data_in = 32'h14;
    n_cmp++; if (dut.r_credit[2] !== 3'd0 || bus.data_ready !== 1'b0) begin n_fail++; $display("FAIL starve_stall: got credit=%0d ready=%b want 0/0", dut.r_credit[2], bus.data_ready); end
    repeat (2) begin
      tick;
      n_cmp++; if (bus.flit_out_we !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL starve_hold: got we=%b busy=%b want 0/1", bus.flit_out_we, bus.busy); end
    end
    bus.credit_in = 4'b0100;
    tick;
    bus.credit_in = 0;
    n_cmp++; if (bus.flit_out_we !== 1'b0 || dut.r_credit[2] !== 3'd1 || bus.data_ready !== 1'b1) begin n_fail++; $display("FAIL starve_credit: got we=%b credit=%0d ready=%b want 0/1/1", bus.flit_out_we, dut.r_credit[2], bus.data_ready); end
    tick;
    n_cmp++; if (bus.flit_out_we !== 1'b1 || bus.flit_out !== mkf(0, 0, 4'b0100, 32'h14)) begin n_fail++; $display("FAIL starve_one: got we=%b flit=%h", bus.flit_out_we, bus.flit_out); end
    n_cmp++; if (bus.data_ready !== 1'b0 || dut.r_credit[2] !== 3'd0) begin n_fail++; $display("FAIL starve_again: got ready=%b credit=%0d want 0/0", bus.data_ready, dut.r_credit[2]); end
    tick;
    n_cmp++; if (bus.flit_out_we !== 1'b0) begin n_fail++; $display("FAIL starve_only_one: got %b want 0", bus.flit_out_we); end
    bus.data_in = 32'h15; bus.credit_in = 4'b0100;
    tick;
    bus.credit_in = 0;
    tick;
    bus.data_valid = 0;
    n_cmp++; if (bus.flit_out_we !== 1'b1 || bus.flit_out !== mkf(0, 1, 4'b0100, 32'h15) || bus.busy !== 1'b0) begin n_fail++; $display("FAIL starve_tail: got we=%b flit=%h busy=%b", bus.flit_out_we, bus.flit_out, bus.busy); end
    bus.credit_in = 4'b0100;
    repeat (4) tick;
    bus.credit_in = 0;
    n_cmp++; if (dut.r_credit[2] !== 3'd4) begin n_fail++; $display("FAIL starve_restore: got %0d want 4", dut.r_credit[2]); end
  endtask

  task automatic test_simul;
    bus.pck_valid = 1; bus.pck_vc = 4'b1000; bus.pck_len = 5'd2; bus.pck_hdr = 32'hBEEF;
    bus.data_valid = 1; bus.data_in = 32'h99;
    tick;
    bus.pck_valid = 0; bus.credit_in = 4'b1000;
    tick;
    bus.credit_in = 0;
    n_cmp++; if (bus.flit_out_we !== 1'b1 || bus.flit_out !== mkf(1, 0, 4'b1000, 32'hBEEF)) begin n_fail++; $display("FAIL simul_hdr: got we=%b flit=%h", bus.flit_out_we, bus.flit_out); end
    n_cmp++; if (dut.r_credit[3] !== 3'd4 || bus.err !== 1'b0) begin n_fail++; $display("FAIL simul_credit: got credit=%0d err=%b want 4/0", dut.r_credit[3], bus.err); end
    tick;
    bus.data_valid = 0;
    n_cmp++; if (bus.flit_out_we !== 1'b1 || bus.flit_out !== mkf(0, 1, 4'b1000, 32'h99) || dut.r_credit[3] !== 3'd3) begin n_fail++; $display("FAIL simul_tail: got we=%b flit=%h credit=%0d", bus.flit_out_we, bus.flit_out, dut.r_credit[3]); end
    bus.credit_in = 4'b1000;
    tick;
    n_cmp++; if (dut.r_credit[3] !== 3'd4 || bus.err !== 1'b0) begin n_fail++; $display("FAIL simul_refill: got credit=%0d err=%b want 4/0", dut.r_credit[3], bus.err); end
    tick;
    bus.credit_in = 0;
    n_cmp++; if (bus.err !== 1'b1 || dut.r_credit[3] !== 3'd4) begin n_fail++; $display("FAIL simul_ovf: got err=%b credit=%0d want 1/4", bus.err, dut.r_credit[3]); end
    tick;
    n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL simul_ovf_pulse: got %b want 0", bus.err); end
  endtask

  task automatic test_invalid;
    bus.pck_valid = 1; bus.pck_vc = 4'b0011; bus.pck_len = 5'd3; bus.pck_hdr = 32'h1;
    tick;
    bus.pck_valid = 0;
    n_cmp++; if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.flit_out_we !== 1'b0 || bus.pck_ready !== 1'b1) begin n_fail++; $display("FAIL inv_vc: got err=%b busy=%b we=%b ready=%b want 1/0/0/1", bus.err, bus.busy, bus.flit_out_we, bus.pck_ready); end
    tick;
    n_cmp++; if (bus.err !== 1'b0 || bus.flit_out_we !== 1'b0) begin n_fail++; $display("FAIL inv_vc_pulse: got err=%b we=%b want 0/0", bus.err, bus.flit_out_we); end
    bus.pck_valid = 1; bus.pck_vc = 4'b0001; bus.pck_len = 5'd0;
    tick;
    bus.pck_valid = 0;
    n_cmp++; if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL inv_len: got err=%b busy=%b want 1/0", bus.err, bus.busy); end
    tick;
    n_cmp++; if (bus.err !== 1'b0 || bus.flit_out_we !== 1'b0) begin n_fail++; $display("FAIL inv_len_pulse: got err=%b we=%b want 0/0", bus.err, bus.flit_out_we); end
    bus.pck_valid = 1; bus.pck_vc = 4'b0010; bus.pck_len = 5'd1; bus.pck_hdr = 32'h5A;
    tick;
    bus.pck_valid = 0;
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL inv_next_busy: got %b want 1", bus.busy); end
    tick;
    n_cmp++; if (bus.flit_out_we !== 1'b1 || bus.flit_out !== mkf(1, 1, 4'b0010, 32'h5A)) begin n_fail++; $display("FAIL inv_next_flit: got we=%b flit=%h", bus.flit_out_we, bus.flit_out); end
    bus.credit_in = 4'b0010;
    tick;
    bus.credit_in = 0;
    n_cmp++; if (dut.r_credit[1] !== 3'd4) begin n_fail++; $display("FAIL inv_restore: got %0d want 4", dut.r_credit[1]); end
  endtask

  task automatic test_reset_mid;
    bus.pck_valid = 1; bus.pck_vc = 4'b0001; bus.pck_len = 5'd5; bus.pck_hdr = 32'h777;
    bus.data_valid = 1; bus.data_in = 32'h21;
    tick;
    bus.pck_valid = 0;
    tick;
    n_cmp++; if (bus.flit_out_we !== 1'b1 || bus.flit_out !== mkf(1, 0, 4'b0001, 32'h777)) begin n_fail++; $display("FAIL mid_hdr: got we=%b flit=%h", bus.flit_out_we, bus.flit_out); end
    tick;
    n_cmp++; if (bus.flit_out_we !== 1'b1 || bus.flit_out !== mkf(0, 0, 4'b0001, 32'h21) || dut.r_credit[0] !== 3'd2) begin n_fail++; $display("FAIL mid_body: got we=%b flit=%h credit=%0d", bus.flit_out_we, bus.flit_out, dut.r_credit[0]); end
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.flit_out !== 38'd0 || bus.flit_out_we !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0) begin n_fail++; $display("FAIL mid_clear: got flit=%h we=%b busy=%b err=%b want all 0", bus.flit_out, bus.flit_out_we, bus.busy, bus.err); end
    n_cmp++; if (dut.r_credit[0] !== 3'd4 || bus.vc_full !== 4'b0000) begin n_fail++; $display("FAIL mid_credit_clear: got credit=%0d full=%b want 4/0000", dut.r_credit[0], bus.vc_full); end
    bus.data_valid = 0;
    tick;
    reset = 1'b1;
    n_cmp++; if (bus.pck_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", bus.pck_ready); end
    for (int v = 0; v < 4; v++) begin
      n_cmp++; if (dut.r_credit[v] !== 3'd4) begin n_fail++; $display("FAIL mid_credit%0d: got %0d want 4", v, dut.r_credit[v]); end
    end
    bus.pck_valid = 1; bus.pck_vc = 4'b0001; bus.pck_len = 5'd1; bus.pck_hdr = 32'h88;
    tick;
    bus.pck_valid = 0;
    tick;
    n_cmp++; if (bus.flit_out_we !== 1'b1 || bus.flit_out !== mkf(1, 1, 4'b0001, 32'h88)) begin n_fail++; $display("FAIL mid_restart: got we=%b flit=%h want we=1 flit=%h", bus.flit_out_we, bus.flit_out, mkf(1, 1, 4'b0001, 32'h88)); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_single;
    test_four;
    test_starve;
    test_simul;
    test_invalid;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
